classroom_game_fsm: RTL and testbench
=====================================

# classroom_game_fsm

Game-state controller that consumes the character status flags (`character_in_door`, `character_in_seat`) and the `professor` look-up input alongside the frame timing from the VGA display controller. It runs the round: countdown timer, task scoring at the door, the caught-standing penalty while the professor looks up, lives, and win/lose resolution. Its registered outputs feed the VGA compositor's HUD/overlay layer and the board-level LEDs and seven-segment display.

## Interface
Parameters:
- `FRAME_TICKS_PER_SEC`, 60: frame ticks per timer second.
- `ROUND_SECONDS`, 90: round length in seconds. Must be ≤127.
- `GRACE_FRAMES`, 30: consecutive out-of-seat frames tolerated while `professor` is high.
- `TASK_FRAMES`, 120: consecutive in-door frames needed to complete one task.
- `WIN_SCORE`, 5: minimum score at timer expiry for a win.
- `START_LIVES`, 3: lives at round start. Must be 1..3.

Ports:
- `ClkPort`  in  1  system clock. Same clock as the display controller.
- `Reset`  in  1  reset, asynchronous, active-high.
- `vSync`  in  1  display-controller vertical sync, active-low, `ClkPort` domain.
- `start`  in  1  start/restart button, asynchronous level.
- `character_in_door`  in  1  character is in the door region.
- `character_in_seat`  in  1  character is in a target seat.
- `professor`  in  1  professor is looking up (switch), asynchronous level.
- `task_enable_switch`  in  1  tasks are enabled (switch), asynchronous level.
- `state`  out  3  encoding: IDLE=0, PLAY=1, CAUGHT=2, WIN=3, LOSE=4.
- `score`  out  8  tasks completed, saturates at 255.
- `lives`  out  2  remaining lives.
- `seconds_left`  out  7  countdown value.
- `caught_flash`  out  1  high throughout the CAUGHT state.
- `game_over`  out  1  high in WIN or LOSE.
- `win`  out  1  high in WIN.

## Operation
- **Input synchronization:**
  - `start`, `character_in_door`, `character_in_seat`, `professor` and `task_enable_switch` each pass through a 2-flop synchronizer.
  - `start_edge` is the rising edge of the synchronized `start`.
- **Frame tick:** `frame_tick` is a one-cycle pulse when the registered `vSync` goes 0→1. All counters below advance only on `frame_tick`.
- **IDLE:**
  - Holds `score`=0, `lives`=START_LIVES, `seconds_left`=ROUND_SECONDS, all counters at 0.
  - `start_edge` → PLAY.
- **PLAY, timer:**
  - `sec_cnt` counts frames 0..FRAME_TICKS_PER_SEC-1.
  - On wrap, `seconds_left` decrements; it never goes below 0.
- **PLAY, task:**
  - Task counting runs only when `task_enable_switch`=1 and `task_armed`=1.
  - In that condition, `door_cnt` increments each tick while `in_door`=1 and clears when `in_door`=0.
  - When `door_cnt` reaches TASK_FRAMES: `score`+1 (saturating), `door_cnt` clears, `task_armed` clears.
  - `task_armed` sets again on the first tick with `in_door`=0.
  - With `task_enable_switch`=0, `door_cnt` is held at 0.
- **PLAY, caught:**
  - `grace_cnt` increments each tick while `professor`=1 and `in_seat`=0. Otherwise it clears.
  - When `grace_cnt` reaches GRACE_FRAMES: `lives`-1, go to CAUGHT, clear `grace_cnt` and `flash_cnt`.
- **PLAY, timer expiry:** when `seconds_left` becomes 0, go to WIN if `score` ≥ WIN_SCORE, else LOSE.
- **Same-tick priority in PLAY:**
  - A caught event beats timer expiry and beats task completion.
  - Any task completion in that same tick is discarded.
- **CAUGHT:**
  - The timer and the task/grace counters freeze.
  - `flash_cnt` counts FRAME_TICKS_PER_SEC ticks, then: LOSE if `lives`=0, else PLAY.
  - On returning to PLAY, `door_cnt` and `grace_cnt` restart from 0.
- **WIN / LOSE:**
  - All values hold.
  - `start_edge` → IDLE, which re-initializes the round.
- **`start_edge` in PLAY or CAUGHT:** ignored.

## Timing
- **Reset values of outputs:**
  - `state`=0, `score`=0, `lives`=START_LIVES, `seconds_left`=ROUND_SECONDS.
  - `caught_flash`=0, `game_over`=0, `win`=0.
- **Reset values of internal state:** all internal counters 0, `task_armed`=1.
- **Output timing:** all outputs are registered. The state-derived flags (`caught_flash`, `game_over`, `win`) change in the same cycle as `state`.
- **`frame_tick` latency:** asserted 2 `ClkPort` cycles after `vSync` is first high at the input.
- **`start` latency:** from `start` rising at the input to `state` changing is 4 cycles (2 sync + edge register + state register).
- **Update cycle:** counter, score, lives and state updates take effect in the cycle after `frame_tick`.
- **Reset mid-operation:** `Reset` asserted in any state returns everything to reset values immediately (asynchronously). The block resumes in IDLE after release.

## Test plan
Bench parameters: FRAME_TICKS_PER_SEC=4, ROUND_SECONDS=5, GRACE_FRAMES=3, TASK_FRAMES=2, WIN_SCORE=2, START_LIVES=2.

- **Start and countdown:** `start` pulse, `professor`=0, `in_seat`=1, run 8 frames → `state`=1, `seconds_left`=3. Pulse `start` again → ignored.
- **Task scoring and re-arm:** `task_enable_switch`=1, `in_door`=1 for 5 frames → `score`=1 only. Drop `in_door` for 1 frame, then raise it for 2 frames → `score`=2. Repeat with `task_enable_switch`=0 → `score` stays 2.
- **Caught once:** `professor`=1, `in_seat`=0 for 3 frames → `state`=2, `lives`=1, `caught_flash`=1 for 4 frames, `seconds_left` frozen, then `state`=1.
- **Caught twice:**
  - A second caught event → `lives`=0, CAUGHT for 4 frames.
  - Then `state`=4, `game_over`=1, `win`=0.
  - `start` pulse → `state`=0, `lives`=2, `score`=0.
- **Timer expiry outcome:**
  - `score`=2 at the 20th frame → `state`=3, `win`=1.
  - `score`=1 at the 20th frame → `state`=4.
- **Simultaneous events:** caught and timer expiry on the same tick → `state`=2 and `lives` decremented. `Reset` asserted mid-CAUGHT → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/classroom_game_fsm.sv
// classroom_game_fsm
//   Round controller for the classroom game. It synchronizes the player and
//   switch inputs and derives a frame tick from the display controller's
//   vSync. It then runs the countdown timer, task scoring at the door, the
//   caught-standing penalty, lives, and win/lose resolution.
//
// Ports
//   ClkPort            in   system clock (display-controller clock)
//   Reset              in   asynchronous, active-high reset
//   vSync              in   vertical sync, active-low, ClkPort domain
//   start              in   start/restart button (async level)
//   character_in_door  in   character is inside the door region
//   character_in_seat  in   character is sitting in a target seat
//   professor          in   professor is looking up (async level)
//   task_enable_switch in   tasks enabled (async level)
//   state        [2:0] out  IDLE=0 PLAY=1 CAUGHT=2 WIN=3 LOSE=4
//   score        [7:0] out  tasks completed, saturating
//   lives        [1:0] out  remaining lives
//   seconds_left [6:0] out  countdown value
//   caught_flash       out  high while in CAUGHT
//   game_over          out  high in WIN or LOSE
//   win                out  high in WIN
module classroom_game_fsm #(
    parameter int FRAME_TICKS_PER_SEC = 60,
    parameter int ROUND_SECONDS       = 90,
    parameter int GRACE_FRAMES        = 30,
    parameter int TASK_FRAMES         = 120,
    parameter int WIN_SCORE           = 5,
    parameter int START_LIVES         = 3
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       vSync,
    input  logic       start,
    input  logic       character_in_door,
    input  logic       character_in_seat,
    input  logic       professor,
    input  logic       task_enable_switch,
    output logic [2:0] state,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [6:0] seconds_left,
    output logic       caught_flash,
    output logic       game_over,
    output logic       win
);

    localparam logic [15:0] LP_FPS   = 16'(FRAME_TICKS_PER_SEC);
    localparam logic [15:0] LP_GRACE = 16'(GRACE_FRAMES);
    localparam logic [15:0] LP_TASK  = 16'(TASK_FRAMES);
    localparam logic [6:0]  LP_ROUND = 7'(ROUND_SECONDS);
    localparam logic [7:0]  LP_WIN   = 8'(WIN_SCORE);
    localparam logic [1:0]  LP_LIVES = 2'(START_LIVES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_CAUGHT = 3'd2,
        ST_WIN    = 3'd3,
        ST_LOSE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers: bit 0 start, 1 door, 2 seat, 3 professor,
    // 4 task enable.
    // ------------------------------------------------------------------
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic       w_start_s;
    logic       w_in_door;
    logic       w_in_seat;
    logic       w_prof;
    logic       w_task_en;

    assign w_start_s = r_sync2[0];
    assign w_in_door = r_sync2[1];
    assign w_in_seat = r_sync2[2];
    assign w_prof    = r_sync2[3];
    assign w_task_en = r_sync2[4];

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {task_enable_switch, professor, character_in_seat,
                        character_in_door, start};
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Start edge and frame tick. The vSync history resets high (its idle
    // level) so releasing reset never produces a spurious frame tick.
    // ------------------------------------------------------------------
    logic r_start_prev;
    logic r_start_edge;
    logic r_vsync_q;
    logic r_vsync_qq;
    logic r_frame_tick;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_start_prev <= 1'b0;
            r_start_edge <= 1'b0;
            r_vsync_q    <= 1'b1;
            r_vsync_qq   <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_start_prev <= w_start_s;
            r_start_edge <= w_start_s & ~r_start_prev;
            r_vsync_q    <= vSync;
            r_vsync_qq   <= r_vsync_q;
            r_frame_tick <= r_vsync_q & ~r_vsync_qq;
        end
    end

    // ------------------------------------------------------------------
    // Game state
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_score;
    logic [7:0]  w_score_next;
    logic [1:0]  r_lives;
    logic [1:0]  w_lives_next;
    logic [6:0]  r_secs;
    logic [6:0]  w_secs_next;
    logic [15:0] r_sec_cnt;
    logic [15:0] w_sec_cnt_next;
    logic [15:0] r_door_cnt;
    logic [15:0] w_door_next;
    logic [15:0] r_grace_cnt;
    logic [15:0] w_grace_next;
    logic [15:0] r_flash_cnt;
    logic [15:0] w_flash_next;
    logic        r_task_armed;
    logic        w_armed_next;
    logic        w_task_done;
    logic        w_caught;
    logic        w_reinit;
    logic        r_caught_flash;
    logic        r_game_over;
    logic        r_win;

    always_comb begin
        w_state_next   = r_state;
        w_score_next   = r_score;
        w_lives_next   = r_lives;
        w_secs_next    = r_secs;
        w_sec_cnt_next = r_sec_cnt;
        w_door_next    = r_door_cnt;
        w_grace_next   = r_grace_cnt;
        w_flash_next   = r_flash_cnt;
        w_armed_next   = r_task_armed;
        w_task_done    = 1'b0;
        w_caught       = 1'b0;
        w_reinit       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_reinit = 1'b1;
                if (r_start_edge) begin
                    w_state_next = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (r_frame_tick) begin
                    // Countdown timer
                    if (r_sec_cnt == LP_FPS - 16'd1) begin
                        w_sec_cnt_next = '0;
                        if (r_secs != '0) begin
                            w_secs_next = r_secs - 7'd1;
                        end
                    end else begin
                        w_sec_cnt_next = r_sec_cnt + 16'd1;
                    end

                    // Task at the door; also covers the disabled and
                    // just-completed (disarmed) cases, which hold door_cnt at 0.
                    if (w_task_en && r_task_armed && w_in_door) begin
                        if (r_door_cnt + 16'd1 == LP_TASK) begin
                            w_task_done  = 1'b1;
                            w_door_next  = '0;
                            w_armed_next = 1'b0;
                        end else begin
                            w_door_next = r_door_cnt + 16'd1;
                        end
                    end else begin
                        w_door_next = '0;
                    end
                    if (!r_task_armed && !w_in_door) begin
                        w_armed_next = 1'b1;
                    end

                    // Caught standing while the professor looks up
                    if (w_prof && !w_in_seat) begin
                        if (r_grace_cnt + 16'd1 == LP_GRACE) begin
                            w_caught = 1'b1;
                        end else begin
                            w_grace_next = r_grace_cnt + 16'd1;
                        end
                    end else begin
                        w_grace_next = '0;
                    end

                    // A caught event overrides expiry and drops any task
                    // completion from the same tick; the timer still advances.
                    if (w_caught) begin
                        w_lives_next = r_lives - 2'd1;
                        w_state_next = ST_CAUGHT;
                        w_grace_next = '0;
                        w_flash_next = '0;
                        w_door_next  = '0;
                        w_armed_next = r_task_armed;
                    end else begin
                        if (w_task_done && r_score != 8'hFF) begin
                            w_score_next = r_score + 8'd1;
                        end
                        if (w_secs_next == '0) begin
                            w_state_next = (w_score_next >= LP_WIN) ? ST_WIN : ST_LOSE;
                        end
                    end
                end
            end

            ST_CAUGHT: begin
                if (r_frame_tick) begin
                    if (r_flash_cnt + 16'd1 == LP_FPS) begin
                        w_flash_next = '0;
                        w_door_next  = '0;
                        w_grace_next = '0;
                        w_state_next = (r_lives == '0) ? ST_LOSE : ST_PLAY;
                    end else begin
                        w_flash_next = r_flash_cnt + 16'd1;
                    end
                end
            end

            ST_WIN, ST_LOSE: begin
                if (r_start_edge) begin
                    w_reinit     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_reinit) begin
            w_score_next   = '0;
            w_lives_next   = LP_LIVES;
            w_secs_next    = LP_ROUND;
            w_sec_cnt_next = '0;
            w_door_next    = '0;
            w_grace_next   = '0;
            w_flash_next   = '0;
            w_armed_next   = 1'b1;
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_score        <= '0;
            r_lives        <= LP_LIVES;
            r_secs         <= LP_ROUND;
            r_sec_cnt      <= '0;
            r_door_cnt     <= '0;
            r_grace_cnt    <= '0;
            r_flash_cnt    <= '0;
            r_task_armed   <= 1'b1;
            r_caught_flash <= 1'b0;
            r_game_over    <= 1'b0;
            r_win          <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_score        <= w_score_next;
            r_lives        <= w_lives_next;
            r_secs         <= w_secs_next;
            r_sec_cnt      <= w_sec_cnt_next;
            r_door_cnt     <= w_door_next;
            r_grace_cnt    <= w_grace_next;
            r_flash_cnt    <= w_flash_next;
            r_task_armed   <= w_armed_next;
            r_caught_flash <= (w_state_next == ST_CAUGHT);
            r_game_over    <= (w_state_next == ST_WIN) || (w_state_next == ST_LOSE);
            r_win          <= (w_state_next == ST_WIN);
        end
    end

    assign state        = r_state;
    assign score        = r_score;
    assign lives        = r_lives;
    assign seconds_left = r_secs;
    assign caught_flash = r_caught_flash;
    assign game_over    = r_game_over;
    assign win          = r_win;

endmodule

// File: tb/tb_classroom_game_fsm.sv
// tb_classroom_game_fsm
//   Frame-level reference model of the round rules plus a per-cycle
//   compare process, directed scenarios with literal expectations and a
//   randomized phase with sticky random inputs and random start presses.
module tb_classroom_game_fsm;

    localparam int FPS   = 4;
    localparam int ROUND = 5;
    localparam int GRACE = 3;
    localparam int TASKF = 2;
    localparam int WINS  = 2;
    localparam int LIVES = 2;

    localparam int S_IDLE   = 0;
    localparam int S_PLAY   = 1;
    localparam int S_CAUGHT = 2;
    localparam int S_WIN    = 3;
    localparam int S_LOSE   = 4;

    logic       ClkPort = 1'b0;
    logic       Reset = 1'b1;
    logic       vSync = 1'b1;
    logic       start = 1'b0;
    logic       character_in_door = 1'b0;
    logic       character_in_seat = 1'b1;
    logic       professor = 1'b0;
    logic       task_enable_switch = 1'b0;
    logic [2:0] state;
    logic [7:0] score;
    logic [1:0] lives;
    logic [6:0] seconds_left;
    logic       caught_flash;
    logic       game_over;
    logic       win;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    classroom_game_fsm #(
        .FRAME_TICKS_PER_SEC(FPS),
        .ROUND_SECONDS(ROUND),
        .GRACE_FRAMES(GRACE),
        .TASK_FRAMES(TASKF),
        .WIN_SCORE(WINS),
        .START_LIVES(LIVES)
    ) dut (
        .ClkPort(ClkPort),
        .Reset(Reset),
        .vSync(vSync),
        .start(start),
        .character_in_door(character_in_door),
        .character_in_seat(character_in_seat),
        .professor(professor),
        .task_enable_switch(task_enable_switch),
        .state(state),
        .score(score),
        .lives(lives),
        .seconds_left(seconds_left),
        .caught_flash(caught_flash),
        .game_over(game_over),
        .win(win)
    );

    always #5 ClkPort = ~ClkPort;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (one step per frame) ----------------
    int m_state, m_score, m_lives, m_play_frames, m_door_run, m_grace_run, m_flash;
    bit m_armed;

    function automatic int m_secs();
        int s;
        s = ROUND - m_play_frames / FPS;
        return (s < 0) ? 0 : s;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_score = 0;
        m_lives = LIVES;
        m_play_frames = 0;
        m_door_run = 0;
        m_grace_run = 0;
        m_flash = 0;
        m_armed = 1'b1;
    endtask

    task automatic model_start();
        if (m_state == S_IDLE) m_state = S_PLAY;
        else if (m_state == S_WIN || m_state == S_LOSE) model_reset();
    endtask

    task automatic model_frame(input bit d, input bit s, input bit p, input bit e);
        bit done, caught, was_armed;
        done = 1'b0;
        caught = 1'b0;
        if (m_state == S_PLAY) begin
            m_play_frames++;
            was_armed = m_armed;
            if (e && d && was_armed) begin
                m_door_run++;
                if (m_door_run == TASKF) begin
                    done = 1'b1;
                    m_door_run = 0;
                    m_armed = 1'b0;
                end
            end else begin
                m_door_run = 0;
            end
            if (!was_armed && !d) m_armed = 1'b1;
            if (p && !s) m_grace_run++;
            else m_grace_run = 0;
            caught = (m_grace_run == GRACE);
            if (caught) begin
                m_lives--;
                m_state = S_CAUGHT;
                m_grace_run = 0;
                m_flash = 0;
                m_door_run = 0;
                m_armed = was_armed;
            end else begin
                if (done && m_score < 255) m_score++;
                if (m_secs() == 0) m_state = (m_score >= WINS) ? S_WIN : S_LOSE;
            end
        end else if (m_state == S_CAUGHT) begin
            m_flash++;
            if (m_flash == FPS) begin
                m_flash = 0;
                m_door_run = 0;
                m_grace_run = 0;
                m_state = (m_lives == 0) ? S_LOSE : S_PLAY;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge ClkPort) begin
        #1;
        if (chk_en && !Reset) begin
            chk("cyc_state", 32'(state), m_state);
            chk("cyc_score", 32'(score), m_score);
            chk("cyc_lives", 32'(lives), m_lives);
            chk("cyc_secs", 32'(seconds_left), m_secs());
            chk("cyc_flash", 32'(caught_flash), (m_state == S_CAUGHT) ? 1 : 0);
            chk("cyc_over", 32'(game_over), (m_state == S_WIN || m_state == S_LOSE) ? 1 : 0);
            chk("cyc_win", 32'(win), (m_state == S_WIN) ? 1 : 0);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_lives"}, 32'(lives), LIVES);
        chk({tag, "_secs"}, 32'(seconds_left), ROUND);
        chk({tag, "_flash"}, 32'(caught_flash), 0);
        chk({tag, "_over"}, 32'(game_over), 0);
        chk({tag, "_win"}, 32'(win), 0);
    endtask

    // ---------------- stimulus helpers ----------------
    // Inputs settle during the vSync-low phase; the model steps between the
    // tick cycle and the edge on which the DUT registers the update.
    task automatic frame(input bit d, input bit s, input bit p, input bit e);
        character_in_door = d;
        character_in_seat = s;
        professor = p;
        task_enable_switch = e;
        vSync = 1'b0;
        repeat (4) @(negedge ClkPort);
        vSync = 1'b1;
        repeat (2) @(negedge ClkPort);
        model_frame(d, s, p, e);
        @(negedge ClkPort);
    endtask

    task automatic press_start();
        start = 1'b1;
        repeat (3) @(negedge ClkPort);
        model_start();
        start = 1'b0;
        repeat (3) @(negedge ClkPort);
    endtask

    task automatic do_reset(input string tag);
        chk_en = 1'b0;
        Reset = 1'b1;
        #1;
        chk_reset_vals(tag);
        repeat (2) @(negedge ClkPort);
        Reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge ClkPort);
    endtask

    bit rd, rs, rp, re;

    initial begin
        repeat (3) @(negedge ClkPort);
        chk_reset_vals("por");
        Reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge ClkPort);

        // Start, countdown, ignored start, caught twice, lose, restart
        press_start();
        chk("A_play", 32'(state), 1);
        repeat (8) frame(0, 1, 0, 0);
        chk("A_secs8", 32'(seconds_left), 3);
        chk("A_pin_model_secs", m_secs(), 3);
        press_start();
        chk("A_start_ignored", 32'(state), 1);
        repeat (3) frame(0, 0, 1, 0);
        chk("A_caught_state", 32'(state), 2);
        chk("A_caught_lives", 32'(lives), 1);
        chk("A_caught_flash", 32'(caught_flash), 1);
        for (int i = 0; i < 3; i++) begin
            frame(0, 0, 1, 0);
            chk("A_still_caught", 32'(state), 2);
            chk("A_secs_frozen", 32'(seconds_left), 3);
        end
        frame(0, 0, 1, 0);
        chk("A_back_play", 32'(state), 1);
        chk("A_back_flash", 32'(caught_flash), 0);
        repeat (3) frame(0, 0, 1, 0);
        chk("A_caught2_state", 32'(state), 2);
        chk("A_caught2_lives", 32'(lives), 0);
        repeat (4) frame(0, 0, 1, 0);
        chk("A_lose_state", 32'(state), 4);
        chk("A_lose_over", 32'(game_over), 1);
        chk("A_lose_win", 32'(win), 0);
        press_start();
        chk("A_restart_state", 32'(state), 0);
        chk("A_restart_lives", 32'(lives), 2);
        chk("A_restart_score", 32'(score), 0);

        // Task scoring, re-arm, disabled tasks, win at expiry
        press_start();
        repeat (5) frame(1, 1, 0, 1);
        chk("B_score1", 32'(score), 1);
        frame(0, 1, 0, 1);
        repeat (2) frame(1, 1, 0, 1);
        chk("B_score2", 32'(score), 2);
        frame(0, 1, 0, 0);
        repeat (3) frame(1, 1, 0, 0);
        chk("B_disabled", 32'(score), 2);
        repeat (7) frame(0, 1, 0, 0);
        chk("B_f19_state", 32'(state), 1);
        chk("B_f19_secs", 32'(seconds_left), 1);
        frame(0, 1, 0, 0);
        chk("B_win_state", 32'(state), 3);
        chk("B_win_flag", 32'(win), 1);
        chk("B_win_secs", 32'(seconds_left), 0);
        press_start();

        // Lose at expiry with score 1
        press_start();
        repeat (2) frame(1, 1, 0, 1);
        chk("C_score1", 32'(score), 1);
        repeat (18) frame(0, 1, 0, 1);
        chk("C_lose_state", 32'(state), 4);
        chk("C_lose_win", 32'(win), 0);
        press_start();
        press_start();

        // Caught on the expiry tick, then reset mid-CAUGHT
        repeat (17) frame(0, 1, 0, 0);
        repeat (3) frame(0, 0, 1, 0);
        chk("D_state", 32'(state), 2);
        chk("D_lives", 32'(lives), 1);
        chk("D_secs", 32'(seconds_left), 0);
        chk("D_pin_model_state", m_state, S_CAUGHT);
        repeat (2) frame(0, 0, 1, 0);
        do_reset("D_rst");

        // Randomized play
        rd = 1'b0; rs = 1'b1; rp = 1'b0; re = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (m_state == S_PLAY || m_state == S_CAUGHT) begin
                if ($urandom_range(0, 15) == 0) press_start();
            end else if ($urandom_range(0, 1) == 0) begin
                press_start();
            end
            if ($urandom_range(0, 3) == 0) rd = ~rd;
            if ($urandom_range(0, 3) == 0) rs = ~rs;
            if ($urandom_range(0, 3) == 0) rp = ~rp;
            if ($urandom_range(0, 7) == 0) re = ~re;
            frame(rd, rs, rp, re);
            if (i == 200) do_reset("R_rst");
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
